// File: rtl/anc_pkg.sv
// Shared definitions for the ANC front end: channel geometry, scheduler FSM
// encoding and small arithmetic helpers.
package anc_pkg;

    localparam int N_CH = 4;
    localparam int DW   = 16;
    localparam int TO_W = 12;

    // Channel lanes inside a frame: error, reference, anti-noise, step size
    localparam int CH_E = 3;
    localparam int CH_X = 2;
    localparam int CH_A = 1;
    localparam int CH_U = 0;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_COLLECT = 2'd1;
    localparam state_t ST_ISSUE   = 2'd2;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_slot.sv
// One channel slot of the frame scheduler: holds the sample collected for the
// frame being built and the last committed value used for substitution.
module frame_slot #(
    parameter int DW = anc_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cap,
    input  logic          clr,
    input  logic          commit,
    input  logic [DW-1:0] din,
    output logic          full,
    output logic [DW-1:0] value
);

    logic [DW-1:0] hold_r;
    logic [DW-1:0] last_r;
    logic          full_r;

    // Capture a sample, or empty the slot and optionally promote it to last value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_r <= {DW{1'b0}};
            last_r <= {DW{1'b0}};
            full_r <= 1'b0;
        end else if (clr) begin
            if (commit && full_r) begin
                last_r <= hold_r;
            end
            full_r <= 1'b0;
        end else if (cap) begin
            hold_r <= din;
            full_r <= 1'b1;
        end
    end

    assign full  = full_r;
    // An empty slot contributes its previous value, so missing/disabled lanes hold
    assign value = full_r ? hold_r : last_r;

endmodule

// File: rtl/frame_sched.sv
// Aligns one sample per enabled channel into a frame for the ANC core, with an
// optional timeout that substitutes late channels with their previous value.
module frame_sched
    import anc_pkg::state_t, anc_pkg::ST_IDLE, anc_pkg::ST_COLLECT, anc_pkg::ST_ISSUE;
#(
    parameter int N_CH = anc_pkg::N_CH,
    parameter int DW   = anc_pkg::DW,
    parameter int TO_W = anc_pkg::TO_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init_done,
    input  logic [N_CH-1:0]      ch_en,
    input  logic [TO_W-1:0]      timeout_cyc,
    input  logic [N_CH-1:0]      ch_vld,
    input  logic [N_CH*DW-1:0]   ch_data,
    output logic [N_CH-1:0]      ch_rdy,
    output logic                 frm_vld,
    input  logic                 frm_rdy,
    output logic [N_CH*DW-1:0]   frm_data,
    output logic [N_CH-1:0]      frm_miss,
    output logic [15:0]          miss_cnt,
    output logic [15:0]          stall_cnt
);

    state_t               state_r;
    state_t               state_nxt_s;
    logic [N_CH-1:0]      en_q_r;
    logic [TO_W-1:0]      cnt_r;
    logic                 frm_vld_r;
    logic [N_CH*DW-1:0]   frm_data_r;
    logic [N_CH-1:0]      frm_miss_r;
    logic [15:0]          miss_cnt_r;
    logic [15:0]          stall_cnt_r;
    logic                 first_r;

    logic [N_CH-1:0]      full_s;
    logic [N_CH-1:0]      cap_s;
    logic [N_CH-1:0]      miss_s;
    logic [N_CH*DW-1:0]   frame_s;
    logic [DW-1:0]        value_s [N_CH];
    logic                 all_full_s;
    logic                 to_hit_s;
    logic                 go_issue_s;
    logic                 accept_s;
    logic                 slot_clr_s;
    logic                 enter_collect_s;
    logic                 stay_collect_s;

    assign ch_rdy = (state_r == ST_COLLECT) ? (~en_q_r | ~full_s) : {N_CH{1'b0}};

    // Frame-completion, timeout and handshake decode
    always_comb begin
        cap_s      = ch_vld & ch_rdy & en_q_r;
        all_full_s = ((full_s & en_q_r) == en_q_r) && (en_q_r != {N_CH{1'b0}});
        // A nonzero cnt_r implies the first capture of the frame has happened
        to_hit_s   = (timeout_cyc != {TO_W{1'b0}}) && (cnt_r == timeout_cyc);
        go_issue_s = (state_r == ST_COLLECT) && init_done && (en_q_r != {N_CH{1'b0}})
                     && (all_full_s || to_hit_s);
        // A capture landing on the expiry edge still counts as present
        miss_s     = en_q_r & ~(full_s | cap_s);
        accept_s   = (state_r == ST_ISSUE) && init_done && frm_rdy;
        slot_clr_s = (state_r == ST_IDLE) || !init_done || accept_s;
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_slot
            frame_slot #(.DW(DW)) u_slot (
                .clk    (clk),
                .rst_n  (rst_n),
                .cap    (cap_s[gi]),
                .clr    (slot_clr_s),
                .commit (accept_s),
                .din    (ch_data[gi*DW +: DW]),
                .full   (full_s[gi]),
                .value  (value_s[gi])
            );
            assign frame_s[gi*DW +: DW] = cap_s[gi] ? ch_data[gi*DW +: DW] : value_s[gi];
        end
    endgenerate

    // Next-state logic; init_done low pulls every state back to IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (init_done) begin
                    state_nxt_s = ST_COLLECT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (!init_done) begin
                    state_nxt_s = ST_IDLE;
                end else if (go_issue_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_COLLECT;
                end
            end
            ST_ISSUE: begin
                if (!init_done) begin
                    state_nxt_s = ST_IDLE;
                end else if (frm_rdy) begin
                    state_nxt_s = ST_COLLECT;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        enter_collect_s = (state_nxt_s == ST_COLLECT) && (state_r != ST_COLLECT);
        stay_collect_s  = (state_nxt_s == ST_COLLECT) && (state_r == ST_COLLECT);
    end

    // State register and per-frame channel enable snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            en_q_r  <= {N_CH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (enter_collect_s) begin
                en_q_r <= ch_en;
            end
        end
    end

    // Timeout counter: starts on the frame's first capture, cleared outside COLLECT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {TO_W{1'b0}};
        end else if (!stay_collect_s) begin
            cnt_r <= {TO_W{1'b0}};
        end else if (cnt_r == {TO_W{1'b0}}) begin
            if (cap_s != {N_CH{1'b0}}) begin
                cnt_r <= {{(TO_W-1){1'b0}}, 1'b1};
            end
        end else if (cnt_r != {TO_W{1'b1}}) begin
            cnt_r <= cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
        end
    end

    // Output frame register, held stable for the whole ISSUE phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_vld_r  <= 1'b0;
            frm_data_r <= {(N_CH*DW){1'b0}};
            frm_miss_r <= {N_CH{1'b0}};
            first_r    <= 1'b0;
        end else begin
            frm_vld_r <= (state_nxt_s == ST_ISSUE);
            first_r   <= go_issue_s;
            if (go_issue_s) begin
                frm_data_r <= frame_s;
                frm_miss_r <= miss_s;
            end
        end
    end

    // Saturating frame statistics, untouched by init_done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_cnt_r  <= 16'd0;
            stall_cnt_r <= 16'd0;
        end else begin
            if (go_issue_s && (miss_s != {N_CH{1'b0}})) begin
                miss_cnt_r <= anc_pkg::sat_inc16(miss_cnt_r);
            end
            if ((state_r == ST_ISSUE) && first_r && init_done && !frm_rdy) begin
                stall_cnt_r <= anc_pkg::sat_inc16(stall_cnt_r);
            end
        end
    end

    assign frm_vld   = frm_vld_r;
    assign frm_data  = frm_data_r;
    assign frm_miss  = frm_miss_r;
    assign miss_cnt  = miss_cnt_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_frame_sched.sv
// Randomized bench for frame_sched with a frame-level reference model of
// arrival times, timeout expiry and last-value substitution.
module tb_frame_sched;

    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_done;
    logic [3:0]  ch_en;
    logic [11:0] timeout_cyc;
    logic [3:0]  ch_vld;
    logic [63:0] ch_data;
    logic [3:0]  ch_rdy;
    logic        frm_vld;
    logic        frm_rdy;
    logic [63:0] frm_data;
    logic [3:0]  frm_miss;
    logic [15:0] miss_cnt;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [15:0] last_m [4];
    int          exp_miss_cnt;
    int          exp_stall_cnt;
    logic [3:0]  cur_en;
    int          f_d [4];
    logic [15:0] f_s [4];

    frame_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_done   (init_done),
        .ch_en       (ch_en),
        .timeout_cyc (timeout_cyc),
        .ch_vld      (ch_vld),
        .ch_data     (ch_data),
        .ch_rdy      (ch_rdy),
        .frm_vld     (frm_vld),
        .frm_rdy     (frm_rdy),
        .frm_data    (frm_data),
        .frm_miss    (frm_miss),
        .miss_cnt    (miss_cnt),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // One frame: arrivals at cycle f_d[i] (NEVER = not sent), sample f_s[i]
    task automatic run_frame(input int to, input int stall, input logic [3:0] next_en,
                             input string tag);
        int t0, mx, e_edge;
        logic [3:0]  miss_e, capk, exp_rdy;
        logic [63:0] exp_data;
        t0 = NEVER; mx = -1; miss_e = 4'b0;
        for (int i = 0; i < 4; i++) begin
            if (cur_en[i]) begin
                if (f_d[i] < t0) t0 = f_d[i];
                if (f_d[i] > mx) mx = f_d[i];
            end
        end
        if (to != 0 && mx - t0 >= to) begin
            e_edge = t0 + to;
            for (int i = 0; i < 4; i++) miss_e[i] = cur_en[i] && (f_d[i] > e_edge);
        end else begin
            e_edge = mx + 1;
        end
        for (int i = 0; i < 4; i++)
            exp_data[i*16 +: 16] = (cur_en[i] && !miss_e[i]) ? f_s[i] : last_m[i];
        if (miss_e != 4'b0) exp_miss_cnt++;

        for (int k = 0; k <= e_edge; k++) begin
            @(negedge clk);
            frm_rdy = 1'b0;
            timeout_cyc = 12'(to);
            ch_en = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                ch_vld[i] = cur_en[i] ? (f_d[i] == k) : 1'($urandom_range(0, 1));
                ch_data[i*16 +: 16] = (cur_en[i] && f_d[i] == k) ? f_s[i] : 16'($urandom);
            end
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) capk[i] = cur_en[i] && (f_d[i] <= k);
            exp_rdy = (k < e_edge) ? ~capk : 4'b0;
            total++;
            if (ch_rdy !== exp_rdy) begin
                bad++;
                $display("FAIL %s ch_rdy k=%0d got=%h exp=%h", tag, k, ch_rdy, exp_rdy);
            end
            total++;
            if (frm_vld !== (k == e_edge)) begin
                bad++;
                $display("FAIL %s frm_vld k=%0d got=%b exp=%b", tag, k, frm_vld, (k == e_edge));
            end
        end
        total++;
        if (frm_data !== exp_data) begin
            bad++;
            $display("FAIL %s frm_data got=%h exp=%h", tag, frm_data, exp_data);
        end
        total++;
        if (frm_miss !== miss_e) begin
            bad++;
            $display("FAIL %s frm_miss got=%b exp=%b", tag, frm_miss, miss_e);
        end
        total++;
        if (miss_cnt !== 16'(exp_miss_cnt)) begin
            bad++;
            $display("FAIL %s miss_cnt got=%0d exp=%0d", tag, miss_cnt, exp_miss_cnt);
        end

        for (int j = 0; j < stall; j++) begin
            @(negedge clk);
            ch_vld = 4'b0;
            frm_rdy = 1'b0;
            @(posedge clk); #1;
            total++;
            if (frm_vld !== 1'b1 || frm_data !== exp_data || ch_rdy !== 4'b0) begin
                bad++;
                $display("FAIL %s stall j=%0d vld=%b data=%h rdy=%h exp_data=%h",
                         tag, j, frm_vld, frm_data, ch_rdy, exp_data);
            end
        end
        if (stall > 0) exp_stall_cnt++;

        @(negedge clk);
        ch_vld = 4'b0;
        frm_rdy = 1'b1;
        ch_en = next_en;
        @(posedge clk); #1;
        total++;
        if (frm_vld !== 1'b0) begin
            bad++;
            $display("FAIL %s accept frm_vld got=%b exp=0", tag, frm_vld);
        end
        total++;
        if (stall_cnt !== 16'(exp_stall_cnt)) begin
            bad++;
            $display("FAIL %s stall_cnt got=%0d exp=%0d", tag, stall_cnt, exp_stall_cnt);
        end
        for (int i = 0; i < 4; i++)
            if (cur_en[i] && !miss_e[i]) last_m[i] = f_s[i];
        cur_en = next_en;
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if (ch_rdy !== 4'b0 || frm_vld !== 1'b0 || frm_data !== 64'b0 || frm_miss !== 4'b0
            || miss_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
            bad++;
            $display("FAIL %s rdy=%h vld=%b data=%h miss=%b mc=%0d sc=%0d exp all zero",
                     tag, ch_rdy, frm_vld, frm_data, frm_miss, miss_cnt, stall_cnt);
        end
    endtask

    task automatic start_collect(input logic [3:0] en);
        @(negedge clk);
        ch_en = en;
        init_done = 1'b1;
        ch_vld = 4'b0;
        frm_rdy = 1'b0;
        @(posedge clk); #1;
        cur_en = en;
        total++;
        if (ch_rdy !== 4'hF) begin
            bad++;
            $display("FAIL start ch_rdy got=%h exp=f", ch_rdy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; init_done = 1'b0; ch_en = 4'b0; timeout_cyc = 12'd0;
        ch_vld = 4'b0; ch_data = 64'b0; frm_rdy = 1'b0;
        for (int i = 0; i < 4; i++) last_m[i] = 16'd0;
        exp_miss_cnt = 0; exp_stall_cnt = 0; cur_en = 4'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        ch_vld = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("idle");
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) begin
            f_d[i] = 0;
            f_s[i] = 16'(i + 1);
        end
        run_frame(0, 0, 4'hF, "basic");
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 4; i++) begin
            f_d[i] = 0;
            f_s[i] = 16'($urandom);
        end
        f_s[0] = 16'h0100;
        run_frame(10, 0, 4'hF, "to_prime");
        for (int i = 0; i < 4; i++) f_s[i] = 16'($urandom);
        f_d[0] = NEVER;
        run_frame(10, 0, 4'b1110, "timeout");
    endtask

    task automatic test_disabled();
        for (int i = 0; i < 4; i++) begin
            f_d[i] = $urandom_range(0, 4);
            f_s[i] = 16'($urandom);
        end
        run_frame(0, 0, 4'hF, "disabled");
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) begin
            f_d[i] = $urandom_range(0, 3);
            f_s[i] = 16'($urandom);
        end
        run_frame(0, 5, 4'hF, "stall");
    endtask

    task automatic test_random();
        for (int f = 0; f < 24; f++) begin
            int         to;
            logic [3:0] nx;
            bit         any;
            to = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 8);
            any = 1'b0;
            for (int i = 0; i < 4; i++) begin
                f_s[i] = 16'($urandom);
                f_d[i] = $urandom_range(0, 7);
                if (to != 0 && $urandom_range(0, 3) == 0) f_d[i] = NEVER;
                if (cur_en[i] && f_d[i] != NEVER) any = 1'b1;
            end
            if (!any) begin
                for (int i = 0; i < 4; i++) f_d[i] = 0;
            end
            nx = (f == 23) ? 4'hF : 4'($urandom_range(1, 15));
            run_frame(to, $urandom_range(0, 3), nx, "rand");
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        frm_rdy = 1'b0; timeout_cyc = 12'd0;
        ch_vld = 4'b0001; ch_data = {$urandom, $urandom};
        @(posedge clk); #1;
        total++;
        if (ch_rdy !== 4'b1110) begin
            bad++;
            $display("FAIL rstmid slot0 ch_rdy got=%h exp=e", ch_rdy);
        end
        @(negedge clk);
        ch_vld = 4'b0010;
        @(posedge clk); #1;
        total++;
        if (ch_rdy !== 4'b1100) begin
            bad++;
            $display("FAIL rstmid slot1 ch_rdy got=%h exp=c", ch_rdy);
        end
        @(negedge clk);
        ch_vld = 4'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rstmid");
        for (int i = 0; i < 4; i++) last_m[i] = 16'd0;
        exp_miss_cnt = 0; exp_stall_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        start_collect(4'hF);
        f_d[0] = 3; f_d[1] = 3; f_d[2] = 0; f_d[3] = 0;
        for (int i = 0; i < 4; i++) f_s[i] = 16'($urandom);
        run_frame(0, 0, 4'hF, "rstnew");
    endtask

    initial begin
        test_reset();
        start_collect(4'hF);
        test_basic();
        test_timeout();
        test_disabled();
        test_stall();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_sched.md
FRAME_SCHED -- requirements
Module: frame_sched

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of input channels (bit 3=e, 2=x, 1=a, 0=u).
REQ-002 SHALL have parameter DW, default 16, sample width (signed two's complement).
REQ-003 SHALL have parameter TO_W, default 12, timeout counter width.
REQ-004 SHALL have port clk  input  1  clock, all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port init_done  input  1  configuration complete, enables scheduling.
REQ-007 SHALL have port ch_en  input  N_CH  per-channel enable.
REQ-008 SHALL have port timeout_cyc  input  TO_W  frame timeout in clk cycles, 0 = disabled.
REQ-009 SHALL have port ch_vld  input  N_CH  per-channel sample valid.
REQ-010 SHALL have port ch_data  input  N_CH*DW  per-channel samples, channel i at [i*DW +: DW].
REQ-011 SHALL have port ch_rdy  output  N_CH  per-channel ready.
REQ-012 SHALL have port frm_vld  output  1  aligned frame valid.
REQ-013 SHALL have port frm_rdy  input  1  downstream (ANC core) ready.
REQ-014 SHALL have port frm_data  output  N_CH*DW  aligned frame, same packing as ch_data.
REQ-015 SHALL have port frm_miss  output  N_CH  channels substituted with previous value in this frame.
REQ-016 SHALL have port miss_cnt  output  16  saturating count of frames with any frm_miss bit set.
REQ-017 SHALL have port stall_cnt  output  16  saturating count of frames not accepted on first frm_vld cycle.

Function
REQ-018 SHALL implement FSM IDLE, COLLECT, ISSUE; IDLE -> COLLECT when init_done=1.
REQ-019 SHALL latch ch_en into en_q on every entry to COLLECT; ch_en changes mid-frame take effect next frame.
REQ-020 SHALL, in COLLECT, drive ch_rdy[i]=1 for enabled channel i while slot i empty; capture on ch_vld[i]&&ch_rdy[i] and mark slot full.
REQ-021 SHALL drive ch_rdy[i]=1 for disabled channels in COLLECT and discard their data; frame uses slot's last captured value (u step size holds).
REQ-022 SHALL drive ch_rdy=0 in IDLE and ISSUE.
REQ-023 SHALL go COLLECT -> ISSUE the cycle after all enabled slots are full (last capture at cycle N -> frm_vld=1 at N+1).
REQ-024 SHALL start the timeout counter at the first capture of a frame; when count reaches timeout_cyc (nonzero) with slots missing, go to ISSUE, fill missing slots with last values, set corresponding frm_miss bits.
REQ-025 SHALL treat timeout expiry coincident with the last capture as a complete frame (frm_miss=0).
REQ-026 SHALL hold frm_vld, frm_data, frm_miss stable in ISSUE until frm_vld&&frm_rdy; then return to COLLECT with slots empty, counter cleared.
REQ-027 SHALL increment miss_cnt once per issued frame with frm_miss!=0; stall_cnt once per frame with frm_rdy=0 on first ISSUE cycle; both saturate at 16'hFFFF.
REQ-028 SHALL, with en_q all-zero, remain in COLLECT and issue no frames.
REQ-029 SHALL return to IDLE, clear slots and counter (not last values, not statistics) when init_done falls in any state.

Reset
REQ-030 SHALL on rst_n=0 set state IDLE, ch_rdy=0, frm_vld=0, frm_data=0, frm_miss=0, last values=0, slots empty, en_q=0, timeout counter=0, miss_cnt=0, stall_cnt=0.
REQ-031 SHALL abort any partial frame on reset mid-operation; no frm_vld until a full new frame is collected.

Structure
REQ-032 SHALL take N_CH, DW, channel index constants CH_E=3, CH_X=2, CH_A=1, CH_U=0 and FSM state typedef from shared package anc_pkg.
REQ-033 SHALL instantiate one sub-module frame_slot per channel (holding register, full flag, last value).

Verification
REQ-034 SHALL verify: init_done=1, ch_en=4'hF, all four vld same cycle with 16'h0001..16'h0004 -> frm_vld next cycle, frm_data packs values, frm_miss=0.
REQ-035 SHALL verify: timeout_cyc=10, ch_en=4'hF, only e,x,a arrive, u last=16'h0100 -> frm_vld 10 cycles after first capture, u=16'h0100, frm_miss=4'b0001, miss_cnt=1.
REQ-036 SHALL verify: ch_en=4'b1110, u vld pulses -> ch_rdy[0]=1, u data ignored, frame issues on e,x,a only.
REQ-037 SHALL verify: frm_rdy=0 for 5 cycles during ISSUE -> frm_data stable, ch_rdy=0, stall_cnt=1, accept on 6th cycle.
REQ-038 SHALL verify: rst_n low after two slots captured -> all outputs reset values within same cycle, next frame needs all four channels.
